// File: rtl/ew_gate_pkg.sv
// Shared constants and lane/tile types for the ew-gate tile stream.
// Tiles are packed with lane 0 in the least-significant DATA_WIDTH bits.
package ew_gate_pkg;
  localparam int TILE_SIZE  = 4;
  localparam int DATA_WIDTH = 16;
  localparam int D          = 256;
  localparam int TILES      = D / TILE_SIZE;
  localparam int TADDR_W    = $clog2(TILES);

  typedef logic signed [DATA_WIDTH-1:0] lane_t;
  typedef lane_t tile_t [TILE_SIZE];
  typedef lane_t [TILE_SIZE-1:0] tile_bits_t;

  // The buffer select forms the MSB of the RAM address.
  function automatic logic [TADDR_W:0] ram_addr(input logic buf_sel,
                                                input logic [TADDR_W-1:0] idx);
    return {buf_sel, idx};
  endfunction
endpackage

// File: rtl/tile_pingpong_ram.sv
// Two-vector ping-pong tile store: one write port, one read port.
// The read data register resets to zero; the array itself is not reset.
module tile_pingpong_ram
  import ew_gate_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [TADDR_W:0]   waddr,
  input  tile_bits_t         wdata,
  input  logic               re,
  input  logic [TADDR_W:0]   raddr,
  output tile_bits_t         rdata
);
  tile_bits_t mem [2*TILES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ew_gate_y_tile_collector.sv
// Collects TILES consecutive tiles into one vector in a ping-pong buffer and
// presents completed vectors to a consumer that reads by tile address then releases.
module ew_gate_y_tile_collector
  import ew_gate_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               y_axis_TVALID,
  output logic               y_axis_TREADY,
  input  tile_bits_t         y_axis_TDATA,
  output logic               vec_valid,
  input  logic               vec_ready,
  input  logic               rd_en,
  input  logic [TADDR_W-1:0] rd_addr,
  output tile_bits_t         rd_data,
  output logic [CNT_W-1:0]   vec_cnt
);
  // Handshakes: a tile moves on TVALID&TREADY, a vector is released on
  // vec_valid&vec_ready; neither ready depends combinationally on its valid.
  logic               wbuf, rbuf, wbuf_next;
  logic [TADDR_W-1:0] widx;
  logic [1:0]         full, full_next;
  logic               tready_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, last, release_vec;

  assign accept      = y_axis_TVALID & tready_q;
  assign last        = accept & (widx == TADDR_W'(TILES - 1));
  assign vec_valid   = full[rbuf];
  assign release_vec = vec_valid & vec_ready;
  assign wbuf_next   = wbuf ^ last;

  // Fill needs !full and release needs full, so they never hit the same buffer.
  always_comb begin
    full_next = full;
    if (last)        full_next[wbuf] = 1'b1;
    if (release_vec) full_next[rbuf] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf     <= 1'b0;
      rbuf     <= 1'b0;
      widx     <= '0;
      full     <= '0;
      tready_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      full     <= full_next;
      wbuf     <= wbuf_next;
      tready_q <= !full_next[wbuf_next];
      if (accept) widx <= last ? '0 : widx + TADDR_W'(1);
      if (release_vec) begin
        rbuf  <= !rbuf;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign y_axis_TREADY = tready_q;
  assign vec_cnt       = cnt_q;

  tile_pingpong_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (ram_addr(wbuf, widx)),
    .wdata (y_axis_TDATA),
    .re    (rd_en),
    .raddr (ram_addr(rbuf, rd_addr)),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_ew_gate_y_tile_collector.sv
// Directed bench for the y-axis tile collector: reset, single vector, backpressure,
// release/fill overlap, randomised signed traffic and release-counter wrap.
module tb_ew_gate_y_tile_collector;
  import ew_gate_pkg::*;

  localparam int TW = TILE_SIZE * DATA_WIDTH;
  localparam int NV = 150;

  logic          clk = 1'b0;
  logic          rst;
  logic          y_axis_TVALID, y_axis_TREADY;
  logic [TW-1:0] y_axis_TDATA;
  logic          vec_valid, vec_ready, rd_en;
  logic [TADDR_W-1:0] rd_addr;
  logic [TW-1:0] rd_data;
  logic [15:0]   vec_cnt;
  logic          tready_w, valid_w;
  logic [TW-1:0] rd_data_w;
  logic [2:0]    vec_cnt_w;

  int n_tests = 0;
  int n_fail  = 0;
  int rel_cnt = 0;
  int waited;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] d;

  always #5 clk = ~clk;

  ew_gate_y_tile_collector u_dut (
    .clk(clk), .rst(rst), .y_axis_TVALID(y_axis_TVALID), .y_axis_TREADY(y_axis_TREADY),
    .y_axis_TDATA(y_axis_TDATA), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .vec_cnt(vec_cnt)
  );

  // Same stimulus, 3-bit counter so the wrap is reachable quickly.
  ew_gate_y_tile_collector #(.CNT_W(3)) u_dut_w (
    .clk(clk), .rst(rst), .y_axis_TVALID(y_axis_TVALID), .y_axis_TREADY(tready_w),
    .y_axis_TDATA(y_axis_TDATA), .vec_valid(valid_w), .vec_ready(vec_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w), .vec_cnt(vec_cnt_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tile(input logic [TW-1:0] data, output int cycles);
    logic t;
    bit   done;
    cycles = 0;
    done   = 0;
    y_axis_TVALID = 1'b1;
    y_axis_TDATA  = data;
    while (!done) begin
      t = y_axis_TREADY;
      step();
      cycles++;
      if (t) begin
        exp_q.push_back(data);
        done = 1;
      end else if (cycles >= 2000) begin
        fail_now("send_tile");
        done = 1;
      end
    end
    y_axis_TVALID = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!vec_valid && n < 5000) begin
      step();
      n++;
    end
    if (!vec_valid) fail_now(tag);
  endtask

  task automatic read_vec_check(input string tag);
    logic [TW-1:0] e;
    check({tag, "_valid"}, 64'(vec_valid), 64'd1);
    if (exp_q.size() < TILES) begin
      fail_now({tag, "_queue"});
    end else begin
      for (int a = 0; a < TILES; a++) begin
        rd_en   = 1'b1;
        rd_addr = TADDR_W'(a);
        step();
        e = exp_q.pop_front();
        check({tag, "_data"}, rd_data, e);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic release_now();
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    rel_cnt++;
    check("vec_cnt", 64'(vec_cnt), 64'(rel_cnt % 65536));
    check("vec_cnt_wrap", 64'(vec_cnt_w), 64'(rel_cnt % 8));
  endtask

  function automatic logic [TW-1:0] ramp_tile(input int k);
    logic [TW-1:0] t;
    for (int i = 0; i < TILE_SIZE; i++) t[i*DATA_WIDTH +: DATA_WIDTH] = 16'(TILE_SIZE*k + i);
    return t;
  endfunction

  function automatic logic [TW-1:0] signed_tile();
    logic [TW-1:0] t;
    for (int i = 0; i < TILE_SIZE; i++) begin
      case ($urandom_range(0, 3))
        0:       t[i*DATA_WIDTH +: DATA_WIDTH] = 16'h8000;
        1:       t[i*DATA_WIDTH +: DATA_WIDTH] = 16'h7FFF;
        default: t[i*DATA_WIDTH +: DATA_WIDTH] = 16'($urandom);
      endcase
    end
    return t;
  endfunction

  initial begin
    rst = 1'b1; y_axis_TVALID = 1'b0; y_axis_TDATA = '0;
    vec_ready = 1'b0; rd_en = 1'b0; rd_addr = '0;
    step(); step();
    check("rst_tready", 64'(y_axis_TREADY), 64'd0);
    check("rst_valid", 64'(vec_valid), 64'd0);
    check("rst_cnt", 64'(vec_cnt), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    rst = 1'b0;
    step();
    check("tready_after_rst", 64'(y_axis_TREADY), 64'd1);

    // T1: partial vector then reset mid-stream
    for (int k = 0; k < 10; k++) send_tile({$urandom, $urandom}, waited);
    rst = 1'b1;
    #1;
    check("t1_tready", 64'(y_axis_TREADY), 64'd0);
    check("t1_valid", 64'(vec_valid), 64'd0);
    check("t1_cnt", 64'(vec_cnt), 64'd0);
    step();
    rst = 1'b0;
    exp_q.delete();
    step();

    // T2: one ramp vector; the 10 discarded tiles must not count toward it
    for (int k = 0; k < TILES; k++) begin
      send_tile(ramp_tile(k), waited);
      if (k == TILES - 2) check("t2_not_yet_valid", 64'(vec_valid), 64'd0);
    end
    check("t2_valid_rise", 64'(vec_valid), 64'd1);
    rd_en = 1'b1; rd_addr = 6'd5;
    step();
    rd_en = 1'b0;
    check("t2_addr5", rd_data, 64'h0017_0016_0015_0014);
    step();
    check("t2_rd_hold", rd_data, 64'h0017_0016_0015_0014);
    read_vec_check("t2");
    release_now();

    // T3: fill both buffers with no release
    for (int k = 0; k < 2*TILES; k++) begin
      send_tile({$urandom, $urandom}, waited);
      check("t3_no_stall", 64'(waited), 64'd1);
    end
    check("t3_tready_full", 64'(y_axis_TREADY), 64'd0);
    d = 64'hA5A5_0001_8000_7FFF;
    y_axis_TVALID = 1'b1;
    y_axis_TDATA  = d;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t3_held_off", 64'(y_axis_TREADY), 64'd0);
    end
    read_vec_check("t3");
    release_now();
    check("t3_tready_back", 64'(y_axis_TREADY), 64'd1);
    send_tile(d, waited);
    check("t3_accept_latency", 64'(waited), 64'd1);

    // T4: release one buffer on the same edge the other's last tile lands
    read_vec_check("t4a");
    for (int k = 1; k < TILES - 1; k++) send_tile({$urandom, $urandom}, waited);
    vec_ready = 1'b1;
    send_tile({$urandom, $urandom}, waited);
    vec_ready = 1'b0;
    rel_cnt++;
    check("t4_accept_latency", 64'(waited), 64'd1);
    check("t4_valid_kept", 64'(vec_valid), 64'd1);
    check("t4_cnt", 64'(vec_cnt), 64'd3);
    check("t4_tready", 64'(y_axis_TREADY), 64'd1);
    read_vec_check("t4b");
    release_now();
    check("t4_drained", 64'(vec_valid), 64'd0);

    // T5/T6: random valid gaps, signed extreme lanes, prompt random releases
    fork
      begin
        for (int v = 0; v < NV; v++)
          for (int k = 0; k < TILES; k++) begin
            while ($urandom_range(0, 1) == 0) step();
            send_tile(signed_tile(), waited);
          end
      end
      begin
        for (int v = 0; v < NV; v++) begin
          wait_valid("t5_wait_valid");
          read_vec_check("t5");
          repeat ($urandom_range(0, 2)) step();
          release_now();
        end
      end
    join
    step();
    check("t5_final_cnt", 64'(vec_cnt), 64'(NV + 4));
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t5_final_valid", 64'(vec_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
